// File: rtl/pwm_cap_pkg.sv
// Shared constants for the multi-channel PWM duty capture block:
// parameter defaults and the ranges the design is built for.
package pwm_cap_pkg;

  localparam int NUM_CH_DEF   = 4;
  localparam int NUM_CH_MIN   = 1;
  localparam int NUM_CH_MAX   = 16;

  localparam int WIDTH_DEF    = 11;
  localparam int WIDTH_MIN    = 2;

  localparam int AVG_LOG2_DEF = 0;
  localparam int AVG_LOG2_MIN = 0;
  localparam int AVG_LOG2_MAX = 3;

  localparam int SYNC_EN_DEF  = 1;

endpackage

// File: rtl/pwm_cap_chan.sv
// One PWM capture channel: input synchronizer, high-cycle counter,
// multi-frame accumulator, toggle tracking and stuck-level flags.
module pwm_cap_chan
  import pwm_cap_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int AVG_LOG2 = AVG_LOG2_DEF,
  parameter int SYNC_EN  = SYNC_EN_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_fe,
  input  logic             i_avg_last,
  input  logic             i_pwm,
  output logic [WIDTH-1:0] o_duty,
  output logic             o_stuck_hi,
  output logic             o_stuck_lo
);

  localparam int AW = WIDTH + AVG_LOG2;

  logic             w_s;
  logic             w_toggle_now;
  logic             w_toggled_any;
  logic [AW-1:0]    w_sum;

  logic             r_s_prev;
  logic             r_toggled;
  logic [WIDTH-1:0] r_hi_cnt;
  logic [AW-1:0]    r_acc;
  logic [WIDTH-1:0] r_duty;
  logic             r_stuck_hi;
  logic             r_stuck_lo;

  if (SYNC_EN != 0) begin : g_sync
    logic [1:0] r_sync;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync <= '0;
      end else begin
        r_sync <= {r_sync[0], i_pwm};
      end
    end
    assign w_s = r_sync[1];
  end else begin : g_nosync
    assign w_s = i_pwm;
  end

  // A change seen in the frame-end cycle itself still belongs to the ending frame.
  assign w_toggle_now  = i_en & (w_s ^ r_s_prev);
  assign w_toggled_any = r_toggled | w_toggle_now;
  assign w_sum         = r_acc + AW'(r_hi_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_prev   <= 1'b0;
      r_toggled  <= 1'b0;
      r_hi_cnt   <= '0;
      r_acc      <= '0;
      r_duty     <= '0;
      r_stuck_hi <= 1'b0;
      r_stuck_lo <= 1'b0;
    end else begin
      r_s_prev <= w_s;
      if (i_fe) begin
        r_hi_cnt   <= '0;
        r_toggled  <= 1'b0;
        r_stuck_hi <= ~w_toggled_any & w_s;
        r_stuck_lo <= ~w_toggled_any & ~w_s;
        if (i_avg_last) begin
          r_acc  <= '0;
          r_duty <= WIDTH'(w_sum >> AVG_LOG2);
        end else begin
          r_acc  <= w_sum;
        end
      end else if (i_en) begin
        r_hi_cnt  <= r_hi_cnt + WIDTH'(w_s);
        r_toggled <= w_toggled_any;
      end
    end
  end

  assign o_duty     = r_duty;
  assign o_stuck_hi = r_stuck_hi;
  assign o_stuck_lo = r_stuck_lo;

endmodule

// File: rtl/pwm_capture_mc.sv
// Multi-channel PWM duty capture: shared frame timer and averaging
// sequencer driving NUM_CH independent capture channels.
module pwm_capture_mc
  import pwm_cap_pkg::*;
#(
  parameter int NUM_CH   = NUM_CH_DEF,
  parameter int WIDTH    = WIDTH_DEF,
  parameter int AVG_LOG2 = AVG_LOG2_DEF,
  parameter int SYNC_EN  = SYNC_EN_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [NUM_CH-1:0]             pwm_in,
  output logic [NUM_CH-1:0][WIDTH-1:0]  duty_out,
  output logic                          vld,
  output logic [NUM_CH-1:0]             stuck_hi,
  output logic [NUM_CH-1:0]             stuck_lo
);

  if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX || WIDTH < WIDTH_MIN ||
      AVG_LOG2 < AVG_LOG2_MIN || AVG_LOG2 > AVG_LOG2_MAX) begin : g_param_err
    $error("pwm_capture_mc: parameter out of supported range");
  end

  logic [WIDTH-1:0] r_per_cnt;
  logic             r_vld;
  logic             w_fe;
  logic             w_avg_last;

  assign w_fe = en & (&r_per_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_per_cnt <= '0;
      r_vld     <= 1'b0;
    end else begin
      if (en) begin
        r_per_cnt <= r_per_cnt + WIDTH'(1);
      end
      r_vld <= w_fe & w_avg_last;
    end
  end

  // Without averaging every frame end publishes; otherwise the last of 2^AVG_LOG2 frames does.
  if (AVG_LOG2 > 0) begin : g_avg
    logic [AVG_LOG2-1:0] r_fcnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_fcnt <= '0;
      end else if (w_fe) begin
        r_fcnt <= r_fcnt + AVG_LOG2'(1);
      end
    end
    assign w_avg_last = &r_fcnt;
  end else begin : g_noavg
    assign w_avg_last = 1'b1;
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    pwm_cap_chan #(
      .WIDTH    (WIDTH),
      .AVG_LOG2 (AVG_LOG2),
      .SYNC_EN  (SYNC_EN)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_en       (en),
      .i_fe       (w_fe),
      .i_avg_last (w_avg_last),
      .i_pwm      (pwm_in[gi]),
      .o_duty     (duty_out[gi]),
      .o_stuck_hi (stuck_hi[gi]),
      .o_stuck_lo (stuck_lo[gi])
    );
  end

  assign vld = r_vld;

endmodule

// File: tb/tb_pwm_capture_mc.sv
// Bench for pwm_capture_mc: three configurations share one stimulus and are
// compared every cycle against a frame-level reference model.
module tb_pwm_capture_mc;

  localparam int N     = 4;
  localparam int W     = 11;
  localparam int FRAME = 1 << W;
  localparam int NI    = 3;

  localparam int M_BASIC = 0;
  localparam int M_AVG   = 1;
  localparam int M_HOLD  = 2;
  localparam int M_RAND  = 3;

  function automatic int sync_of(input int i);
    return (i == 1) ? 0 : 1;
  endfunction

  function automatic int avg_of(input int i);
    return (i == 2) ? 2 : 0;
  endfunction

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [N-1:0]  pwm_in = '0;

  logic [N-1:0][W-1:0] duty_w [NI];
  logic                vld_w  [NI];
  logic [N-1:0]        shi_w  [NI];
  logic [N-1:0]        slo_w  [NI];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mode = M_BASIC;
  int hold_base = 0;

  // Reference model state, per instance
  logic [N-1:0]        m_h1   [NI];
  logic [N-1:0]        m_h2   [NI];
  logic [N-1:0]        m_prev [NI];
  logic [N-1:0]        m_tog  [NI];
  int                  m_pos  [NI];
  int                  m_nfr  [NI];
  int                  m_hi   [NI][N];
  int                  m_sum  [NI][N];
  logic [N-1:0][W-1:0] e_duty [NI];
  logic                e_vld  [NI];
  logic                e_fe   [NI];
  logic [N-1:0]        e_shi  [NI];
  logic [N-1:0]        e_slo  [NI];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    pwm_capture_mc #(
      .NUM_CH   (N),
      .WIDTH    (W),
      .AVG_LOG2 (avg_of(gi)),
      .SYNC_EN  (sync_of(gi))
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .pwm_in   (pwm_in),
      .duty_out (duty_w[gi]),
      .vld      (vld_w[gi]),
      .stuck_hi (shi_w[gi]),
      .stuck_lo (slo_w[gi])
    );
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_h1[i] = '0; m_h2[i] = '0; m_prev[i] = '0; m_tog[i] = '0;
      m_pos[i] = 0; m_nfr[i] = 0;
      e_duty[i] = '0; e_vld[i] = 1'b0; e_fe[i] = 1'b0;
      e_shi[i] = '0; e_slo[i] = '0;
      for (int ch = 0; ch < N; ch++) begin
        m_hi[i][ch] = 0;
        m_sum[i][ch] = 0;
      end
    end
    cyc = 0;
  endtask

  // Frame-level behaviour: count high samples of the delayed input, publish the
  // average of every 2^avg frames, judge a frame stuck if its level never changed.
  task automatic model_update();
    for (int i = 0; i < NI; i++) begin
      logic [N-1:0] s;
      s = (sync_of(i) != 0) ? m_h2[i] : pwm_in;
      e_vld[i] = 1'b0;
      e_fe[i]  = 1'b0;
      if (en) begin
        m_tog[i] = m_tog[i] | (s ^ m_prev[i]);
        if (m_pos[i] == FRAME - 1) begin
          e_fe[i] = 1'b1;
          for (int ch = 0; ch < N; ch++) begin
            e_shi[i][ch] = ~m_tog[i][ch] & s[ch];
            e_slo[i][ch] = ~m_tog[i][ch] & ~s[ch];
            m_sum[i][ch] += m_hi[i][ch];
            m_hi[i][ch] = 0;
          end
          m_tog[i] = '0;
          m_pos[i] = 0;
          m_nfr[i]++;
          if (m_nfr[i] == (1 << avg_of(i))) begin
            for (int ch = 0; ch < N; ch++) begin
              e_duty[i][ch] = W'(m_sum[i][ch] >> avg_of(i));
              m_sum[i][ch] = 0;
            end
            m_nfr[i] = 0;
            e_vld[i] = 1'b1;
          end
        end else begin
          for (int ch = 0; ch < N; ch++) m_hi[i][ch] += int'(s[ch]);
          m_pos[i]++;
        end
      end
      m_prev[i] = s;
      m_h2[i]   = m_h1[i];
      m_h1[i]   = pwm_in;
    end
    cyc++;
  endtask

  task automatic compare();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("vld[%0d]", i), 64'(vld_w[i]), 64'(e_vld[i]));
      if (e_fe[i] || (cyc % 61) == 0) begin
        chk($sformatf("duty[%0d]", i), 64'(duty_w[i]), 64'(e_duty[i]));
        chk($sformatf("stuck_hi[%0d]", i), 64'(shi_w[i]), 64'(e_shi[i]));
        chk($sformatf("stuck_lo[%0d]", i), 64'(slo_w[i]), 64'(e_slo[i]));
      end
    end
  endtask

  // Inputs for the current cycle index cyc
  task automatic drive();
    int ph;
    ph = cyc % FRAME;
    case (mode)
      M_BASIC: begin
        pwm_in[0] = 1'b1;
        pwm_in[1] = (ph < 1024);
        pwm_in[2] = 1'b0;
      end
      M_AVG: begin
        pwm_in[0] = (ph < ((((cyc / FRAME) % 2) == 0) ? 1000 : 1004));
        pwm_in[1] = (ph < 1024);
        pwm_in[2] = 1'b0;
      end
      M_HOLD: begin
        pwm_in[0] = 1'b1;
        pwm_in[1] = (cyc >= hold_base) && (cyc < hold_base + 1024);
        pwm_in[2] = 1'b0;
      end
      default: begin
        if ($urandom_range(0, 40) == 0)   pwm_in[0] = ~pwm_in[0];
        if ($urandom_range(0, 400) == 0)  pwm_in[1] = ~pwm_in[1];
        if ($urandom_range(0, 3000) == 0) pwm_in[2] = ~pwm_in[2];
      end
    endcase
    if ($urandom_range(0, 7) == 0) pwm_in[3] = ~pwm_in[3];
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
    drive();
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  initial begin
    logic hold_vld_seen;
    int   hold_left;

    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    mode  = M_BASIC;
    drive();

    // Constant and 50% inputs, first frame
    run_to(FRAME - 1);
    chk("pre_first_vld", 64'(vld_w[0]), 64'd0);
    run_to(FRAME);
    chk("first_vld", 64'(vld_w[0]), 64'd1);
    chk("first_vld_nosync", 64'(vld_w[1]), 64'd1);
    chk("ch0_sync_first", 64'(duty_w[0][0]), 64'd2045);
    chk("ch0_nosync_first", 64'(duty_w[1][0]), 64'd2047);
    chk("ch1_half", 64'(duty_w[0][1]), 64'd1024);
    chk("ch2_zero", 64'(duty_w[0][2]), 64'd0);
    chk("ch2_stuck_lo", 64'(slo_w[0][2]), 64'd1);

    run_to(2 * FRAME);
    chk("ch0_full", 64'(duty_w[0][0]), 64'd2047);
    chk("ch0_stuck_hi", 64'(shi_w[0][0]), 64'd1);
    chk("ch1_half_f2", 64'(duty_w[0][1]), 64'd1024);
    chk("ch1_half_nosync", 64'(duty_w[1][1]), 64'd1024);
    chk("ch1_no_stuck", 64'({shi_w[0][1], slo_w[0][1]}), 64'd0);

    // Averaging over four frames
    run_to(4 * FRAME);
    chk("avg_first_vld", 64'(vld_w[2]), 64'd1);
    mode = M_AVG;
    run_to(12 * FRAME);
    chk("avg_vld", 64'(vld_w[2]), 64'd1);
    chk("avg_1002", 64'(duty_w[2][0]), 64'd1002);

    // Enable hold of 100 cycles mid-frame
    mode = M_HOLD;
    hold_base = 12 * FRAME;
    drive();
    run_to(hold_base + 500);
    en = 1'b0;
    hold_vld_seen = 1'b0;
    while (cyc < hold_base + 600) begin
      step();
      for (int i = 0; i < NI; i++) hold_vld_seen |= vld_w[i];
    end
    chk("hold_no_vld", 64'(hold_vld_seen), 64'd0);
    en = 1'b1;
    run_to(hold_base + FRAME);
    chk("hold_vld_not_yet", 64'(vld_w[0]), 64'd0);
    run_to(hold_base + FRAME + 100);
    chk("hold_vld_delayed", 64'(vld_w[0]), 64'd1);
    chk("hold_duty_sync", 64'(duty_w[0][1]), 64'd924);
    chk("hold_duty_nosync", 64'(duty_w[1][1]), 64'd924);

    // Reset mid-frame
    run_to(hold_base + FRAME + 1000);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_duty[%0d]", i), 64'(duty_w[i]), 64'd0);
      chk($sformatf("rst_vld[%0d]", i), 64'(vld_w[i]), 64'd0);
      chk($sformatf("rst_stuck[%0d]", i), 64'({shi_w[i], slo_w[i]}), 64'd0);
    end
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mode  = M_BASIC;
    drive();
    run_to(FRAME - 1);
    chk("rst_vld_not_yet", 64'(vld_w[0]), 64'd0);
    run_to(FRAME);
    chk("rst_next_vld", 64'(vld_w[0]), 64'd1);

    // Randomized inputs with random enable gaps
    mode = M_RAND;
    hold_left = 0;
    while (cyc < FRAME + 20000) begin
      if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) en = 1'b1;
      end else if ($urandom_range(0, 999) == 0) begin
        en = 1'b0;
        hold_left = $urandom_range(1, 200);
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
